note_hit_scorer: RTL
====================

// Module: note_hit_scorer
// PURPOSE
//  Judges each scheduled recorder note against the FFT pitch-detector stream and
//  converts judged hits into one-cycle `score` pulses for the ASCII score counter.
//  Sits between pitch detection / note scheduler and binaryCounterASCII; tracks
//  combo and score multiplier. Counter adds one point per `score` cycle.
// PARAMETERS
//  NOTE_W      5  width of note index (expected and detected)
//  HOLD_CYCLES 4  consecutive matching pitch samples required for a hit (>=1)
//  COMBO_STEP  8  consecutive hits per multiplier step
//  MAX_MULT    4  multiplier saturation value (<=7)
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       asynchronous, active-low reset
//  note_start    in   1       1-cycle pulse: hit window for a new note opens
//  note_end      in   1       1-cycle pulse: current hit window closes
//  expected_note in   NOTE_W  note to play; sampled when note_start accepted
//  pitch_valid   in   1       1-cycle strobe: pitch_note holds a new FFT result
//  pitch_note    in   NOTE_W  detected note index
//  score         out  1       1-cycle point pulses, consumed by the ASCII counter
//  hit           out  1       1-cycle pulse on judged hit
//  miss          out  1       1-cycle pulse on judged miss
//  perfect       out  1       1-cycle pulse on perfect hit (see CONFIGURATION)
//  combo         out  8       consecutive hits, saturates at 255
//  multiplier    out  3       1 + combo/COMBO_STEP, saturates at MAX_MULT
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; score/hit/miss/perfect/busy=0, combo=0,
//    multiplier=1, match run=0, pending points=0. Reset mid-AWARD aborts pulses at once.
//  - All outputs registered. States: IDLE, WINDOW, AWARD, LOCKED.
//  - IDLE: note_start -> latch expected_note, clear match run, -> WINDOW.
//  - WINDOW: each pitch_valid: run = (pitch_note==expected) ? run+1 : 0.
//    Run reaching HOLD_CYCLES -> next cycle hit=1, combo+=1, multiplier recomputed
//    from new combo, points=new multiplier, -> AWARD. Samples after that ignored.
//    note_end before hit -> next cycle miss=1, combo=0, multiplier=1, -> IDLE.
//    Threshold-reaching sample and note_end in same cycle: hit wins, note_end
//    recorded as pending.
//  - AWARD: score=1 for exactly `points` consecutive cycles, first pulse the cycle
//    after hit. Then -> IDLE if note_end pending/arriving, else -> LOCKED.
//    note_start during AWARD ignored (scheduler guarantees spacing >= MAX_MULT+3).
//  - LOCKED: wait for note_end -> IDLE.
//  - note_end+note_start same cycle in WINDOW/LOCKED: close current note (miss if
//    WINDOW) then accept new note -> WINDOW with fresh expected_note, run=0.
//  - note_end in IDLE, pitch_valid outside WINDOW: ignored. note_start in IDLE
//    with note_end same cycle: start accepted.
//  - combo saturates at 255 (no wrap); multiplier never exceeds MAX_MULT.
// CONFIGURATION
//  PERFECT_BONUS_EN defined: hit whose window contained no non-matching pitch
//    sample before the hit earns points=multiplier+1 and pulses perfect with hit.
//  Undefined: perfect tied 0, points=multiplier, no extra logic.
// TESTING
//  1 reset_n=0 mid-run -> score/hit/miss/busy=0, combo=0, multiplier=1 at once.
//  2 start exp=5; pitch 5,5,5,5 -> hit 1 cycle after 4th sample, exactly 1 score
//    pulse, combo=1, then LOCKED until note_end; busy=0 after note_end.
//  3 exp=5; pitch 5,5,3,5,5,5,5 -> hit only after 7th sample; perfect=0
//    (with PERFECT_BONUS_EN; 5,5,5,5 gives 2 pulses + perfect).
//  4 exp=7; pitch 7,7 then note_end -> miss=1, 0 score pulses, combo=0, multiplier=1.
//  5 24 consecutive hits -> hits 1-7 one pulse, 8th: 2 pulses multiplier=2,
//    16th: 3, 24th+: 4 pulses (saturated); next miss resets to 1.
//  6 combo=8 hit, reset_n=0 during 2nd score pulse -> score=0 immediately, no
//    further pulses, combo=0 after release.

Source files
------------

// File: rtl/note_hit_scorer.sv
// rtl/note_hit_scorer.sv - judges scheduled notes against detected pitch and emits score pulses
// Optional feature: define PERFECT_BONUS_EN for the perfect-hit bonus point.
module note_hit_scorer #(
  parameter int NOTE_W      = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int COMBO_STEP  = 8,
  parameter int MAX_MULT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              note_start,
  input  logic              note_end,
  input  logic [NOTE_W-1:0] expected_note,
  input  logic              pitch_valid,
  input  logic [NOTE_W-1:0] pitch_note,
  output logic              score,
  output logic              hit,
  output logic              miss,
  output logic              perfect,
  output logic [7:0]        combo,
  output logic [2:0]        multiplier,
  output logic              busy
);

  localparam int RUN_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WINDOW, AWARD, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [NOTE_W-1:0] exp_q, exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [7:0]        combo_q, combo_d;
  logic [2:0]        mult_q, mult_d;
  logic [3:0]        points_q, points_d;
  logic              end_pend_q, end_pend_d;
  logic              score_q, score_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              busy_q, busy_d;
`ifdef PERFECT_BONUS_EN
  logic              clean_q, clean_d;
  logic              perfect_q, perfect_d;
`endif

  logic [7:0] combo_inc;
  logic [7:0] combo_div;
  logic [2:0] mult_inc;
  logic       match;
  logic       thresh;

  always_comb begin
    combo_inc = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
    combo_div = combo_inc / 8'(COMBO_STEP);
    mult_inc  = (combo_div >= 8'(MAX_MULT - 1)) ? 3'(MAX_MULT) : 3'(combo_div + 8'd1);
    match     = (pitch_note == exp_q);
    thresh    = pitch_valid && match && (run_q == RUN_W'(HOLD_CYCLES - 1));
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    combo_d    = combo_q;
    mult_d     = mult_q;
    points_d   = points_q;
    end_pend_d = end_pend_q;
    score_d    = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
`ifdef PERFECT_BONUS_EN
    clean_d    = clean_q;
    perfect_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (note_start) begin
          state_d    = WINDOW;
          exp_d      = expected_note;
          run_d      = '0;
          end_pend_d = 1'b0;
`ifdef PERFECT_BONUS_EN
          clean_d    = 1'b1;
`endif
        end
      end
      WINDOW: begin
        // A threshold-reaching sample beats a simultaneous note_end; the end is remembered.
        if (thresh) begin
          state_d    = AWARD;
          hit_d      = 1'b1;
          combo_d    = combo_inc;
          mult_d     = mult_inc;
          points_d   = 4'(mult_inc);
          end_pend_d = note_end;
`ifdef PERFECT_BONUS_EN
          if (clean_q) begin
            points_d  = 4'(mult_inc) + 4'd1;
            perfect_d = 1'b1;
          end
`endif
        end else if (note_end) begin
          state_d = IDLE;
          miss_d  = 1'b1;
          combo_d = 8'd0;
          mult_d  = 3'd1;
          if (note_start) begin
            state_d    = WINDOW;
            exp_d      = expected_note;
            run_d      = '0;
            end_pend_d = 1'b0;
`ifdef PERFECT_BONUS_EN
            clean_d    = 1'b1;
`endif
          end
        end else if (pitch_valid) begin
          run_d = match ? run_q + RUN_W'(1) : '0;
`ifdef PERFECT_BONUS_EN
          clean_d = clean_q & match;
`endif
        end
      end
      AWARD: begin
        if (note_end) end_pend_d = 1'b1;
        if (points_q != 4'd0) begin
          score_d  = 1'b1;
          points_d = points_q - 4'd1;
        end else begin
          state_d = (end_pend_q || note_end) ? IDLE : LOCKED;
        end
      end
      LOCKED: begin
        if (note_end) begin
          state_d = IDLE;
          if (note_start) begin
            state_d    = WINDOW;
            exp_d      = expected_note;
            run_d      = '0;
            end_pend_d = 1'b0;
`ifdef PERFECT_BONUS_EN
            clean_d    = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      run_q      <= '0;
      combo_q    <= 8'd0;
      mult_q     <= 3'd1;
      points_q   <= 4'd0;
      end_pend_q <= 1'b0;
      score_q    <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PERFECT_BONUS_EN
      clean_q    <= 1'b0;
      perfect_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      combo_q    <= combo_d;
      mult_q     <= mult_d;
      points_q   <= points_d;
      end_pend_q <= end_pend_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
`ifdef PERFECT_BONUS_EN
      clean_q    <= clean_d;
      perfect_q  <= perfect_d;
`endif
    end
  end

  assign score      = score_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign combo      = combo_q;
  assign multiplier = mult_q;
  assign busy       = busy_q;
`ifdef PERFECT_BONUS_EN
  assign perfect    = perfect_q;
`else
  assign perfect    = 1'b0;
`endif

endmodule
